// File: rtl/lut_mult_pkg.sv
// Shared definitions for the LUT-based constant multipliers.
//   DIGIT_W   : width of one multiplicand digit
//   state_e   : control state encoding (IDLE/CALC/DONE)
//   build_lut : table of k*A_CONST for k = 0..8 (the magnitude of a recoded digit)
// No ports; imported by the digit sub-module and the top level.
package lut_mult_pkg;

  localparam int DIGIT_W   = 4;
  localparam int LUT_N     = 9;
  // The table is built at a fixed maximum width because a package function
  // cannot see the instantiating module's A_W. Each word of interest only
  // needs A_W+4 bits; the caller keeps those low bits.
  localparam int A_W_MAX   = 32;
  localparam int LUT_W_MAX = A_W_MAX + DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [LUT_W_MAX-1:0] lut_word_t;
  typedef lut_word_t [LUT_N-1:0] lut_t;

  function automatic lut_t build_lut(input logic [A_W_MAX-1:0] a_const);
    lut_t lut;
    for (int k = 0; k < LUT_N; k++) begin
      lut[k] = LUT_W_MAX'(k) * LUT_W_MAX'(a_const);
    end
    return lut;
  endfunction

endpackage

// File: rtl/lut_const_mult_seq_if.sv
// Handshake bundle for lut_const_mult_seq.
//   in_valid/in_ready/x   : operand channel (producer -> multiplier)
//   out_valid/out_ready/p : product channel (multiplier -> consumer)
// slave modport is the multiplier side, master modport is the environment side.
interface lut_const_mult_seq_if #(
  parameter int X_W = 8,
  parameter int P_W = 12
);
  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] x;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] p;

  modport slave (
    input  in_valid, x, out_ready,
    output in_ready, out_valid, p
  );

  modport master (
    output in_valid, x, out_ready,
    input  in_ready, out_valid, p
  );
endinterface

// File: rtl/lut_mult_digit_pp.sv
// Combinational partial-product generator for one 4-bit digit.
// The digit plus incoming carry is recoded to a signed digit d in -8..+8,
// |d|*A_CONST is read from a constant table and negated when d < 0.
//   digit_i : raw 4-bit multiplicand digit
//   carry_i : recoding carry from the next-lower digit
//   pp_o    : signed partial product d*A_CONST (A_W+5 bits)
//   carry_o : recoding carry into the next-higher digit
module lut_mult_digit_pp
  import lut_mult_pkg::*;
#(
  parameter int          A_W     = 4,
  parameter int unsigned A_CONST = 13
) (
  input  logic [DIGIT_W-1:0]  digit_i,
  input  logic                carry_i,
  output logic signed [A_W+4:0] pp_o,
  output logic                carry_o
);

  localparam lut_t LUT = build_lut(A_W_MAX'(A_CONST));

  logic signed [5:0] d_val;
  logic [3:0]        mag;
  logic [A_W+3:0]    word;

  always_comb begin
    // Digits 8..15 borrow 16 from the next digit, so d never leaves -8..+8.
    carry_o = digit_i[DIGIT_W-1];
    d_val   = $signed({2'b00, digit_i}) + $signed({5'b00000, carry_i})
            - (digit_i[DIGIT_W-1] ? 6'sd16 : 6'sd0);
    mag     = d_val[5] ? 4'(-d_val) : d_val[3:0];
    word    = LUT[mag][A_W+3:0];
    pp_o    = d_val[5] ? -$signed({1'b0, word}) : $signed({1'b0, word});
  end

endmodule

// File: rtl/lut_const_mult_seq.sv
// Digit-serial constant multiplier: p = x * A_CONST, one 4-bit digit per
// clock, least significant digit first, with valid/ready on both sides.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any operation in flight
//   bus : lut_const_mult_seq_if.slave
//         in_valid/in_ready/x   operand handshake (in_ready only in IDLE)
//         out_valid/out_ready/p product handshake (p held while out_ready=0)
// Operand accepted at edge E0 gives out_valid after edge E0+D, D = X_W/4.
module lut_const_mult_seq
  import lut_mult_pkg::*;
#(
  parameter int          X_W     = 8,
  parameter int unsigned A_CONST = 13,
  parameter int          A_W     = 4,
  parameter int          SIGNED  = 0
) (
  input  logic clk,
  input  logic rst,
  lut_const_mult_seq_if.slave bus
);

  localparam int P_W   = X_W + A_W;
  localparam int D     = X_W / DIGIT_W;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(D - 1);
  // Unsigned operands whose top digit recodes negative owe one A_CONST at
  // weight 2**X_W; two's complement operands simply drop that carry.
  localparam logic signed [P_W:0] TOP_CARRY = (P_W+1)'(A_CONST) << X_W;

  state_e                state_q, state_d;
  logic [X_W-1:0]        x_q, x_d;
  logic signed [P_W:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic [P_W-1:0]        p_q, p_d;

  logic signed [A_W+4:0] pp;
  logic                  carry_out;
  logic signed [P_W:0]   pp_ext;
  logic signed [P_W:0]   pp_shift;

  // x_q is shifted right each CALC cycle, so the current digit is always
  // its low nibble.
  lut_mult_digit_pp #(
    .A_W     (A_W),
    .A_CONST (A_CONST)
  ) u_digit_pp (
    .digit_i (x_q[DIGIT_W-1:0]),
    .carry_i (carry_q),
    .pp_o    (pp),
    .carry_o (carry_out)
  );

  assign pp_ext   = (P_W+1)'(pp);
  assign pp_shift = pp_ext << {cnt_q, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    p_d     = p_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.x;
          acc_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        acc_d   = acc_q + pp_shift;
        x_d     = x_q >> DIGIT_W;
        carry_d = carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          if ((SIGNED == 0) && carry_out) begin
            acc_d = acc_d + TOP_CARRY;
          end
          p_d     = acc_d[P_W-1:0];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_lut_const_mult_seq.sv
// Self-checking bench for lut_const_mult_seq.
// Four instances share clk/rst:
//   s=0: X_W=8,  A_CONST=13,  SIGNED=0
//   s=1: X_W=8,  A_CONST=13,  SIGNED=1
//   s=2: X_W=16, A_CONST=255, A_W=8, SIGNED=0
//   s=3: X_W=8,  A_CONST=0,   SIGNED=0
// Expected products are computed from x*A_CONST and queued at drive time.
module tb_lut_const_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_const_mult_seq_if #(.X_W(8),  .P_W(12)) if0 ();
  lut_const_mult_seq_if #(.X_W(8),  .P_W(12)) if1 ();
  lut_const_mult_seq_if #(.X_W(16), .P_W(24)) if2 ();
  lut_const_mult_seq_if #(.X_W(8),  .P_W(12)) if3 ();

  lut_const_mult_seq #(.X_W(8), .A_CONST(13), .A_W(4), .SIGNED(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  lut_const_mult_seq #(.X_W(8), .A_CONST(13), .A_W(4), .SIGNED(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  lut_const_mult_seq #(.X_W(16), .A_CONST(255), .A_W(8), .SIGNED(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  lut_const_mult_seq #(.X_W(8), .A_CONST(0), .A_W(4), .SIGNED(0))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  // ---------------- access helpers (no checking) ----------------
  task automatic set_in(input int s, input logic v, input logic [15:0] xv);
    case (s)
      0: begin if0.in_valid = v; if0.x = xv[7:0]; end
      1: begin if1.in_valid = v; if1.x = xv[7:0]; end
      2: begin if2.in_valid = v; if2.x = xv;      end
      default: begin if3.in_valid = v; if3.x = xv[7:0]; end
    endcase
  endtask

  task automatic set_ordy(input int s, input logic v);
    case (s)
      0: if0.out_ready = v;
      1: if1.out_ready = v;
      2: if2.out_ready = v;
      default: if3.out_ready = v;
    endcase
  endtask

  function automatic logic get_ov(input int s);
    case (s)
      0: return if0.out_valid;
      1: return if1.out_valid;
      2: return if2.out_valid;
      default: return if3.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int s);
    case (s)
      0: return if0.in_ready;
      1: return if1.in_ready;
      2: return if2.in_ready;
      default: return if3.in_ready;
    endcase
  endfunction

  function automatic logic [23:0] get_p(input int s);
    case (s)
      0: return 24'(if0.p);
      1: return 24'(if1.p);
      2: return if2.p;
      default: return 24'(if3.p);
    endcase
  endfunction

  function automatic int model(input int s, input logic [15:0] xv);
    case (s)
      0: return (int'(xv[7:0]) * 13) & 32'hFFF;
      1: return (int'($signed(xv[7:0])) * 13) & 32'hFFF;
      2: return (int'(xv) * 255) & 32'hFF_FFFF;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_lat(input int s);
    return (s == 2) ? 4 : 2;
  endfunction

  // One complete operation; hold = cycles out_ready stays low in DONE
  // (0 means out_ready is already high, giving a one-cycle pulse).
  task automatic do_op(input int s, input logic [15:0] xv, input int hold);
    int lat;
    int e;
    logic [23:0] pv;
    @(negedge clk);
    checks++;
    if (get_ir(s) !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_idle s=%0d got=%b want=1", s, get_ir(s));
    end
    set_ordy(s, hold == 0);
    set_in(s, 1'b1, xv);
    exp_q.push_back(model(s, xv));
    @(posedge clk); #1;
    set_in(s, 1'b0, 16'h0);
    lat = 0;
    while (get_ov(s) !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat(s)) begin
      failures++;
      $display("FAIL latency s=%0d x=%h got=%0d want=%0d", s, xv, lat, exp_lat(s));
    end
    e  = exp_q.pop_front();
    pv = get_p(s);
    checks++;
    if (int'(pv) != e) begin
      failures++;
      $display("FAIL product s=%0d x=%h got=%h want=%h", s, xv, pv, e);
    end
    $display("op s=%0d x=%h p=%h exp=%h lat=%0d", s, xv, pv, e, lat);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (get_ov(s) !== 1'b1 || get_ir(s) !== 1'b0 || get_p(s) !== pv) begin
        failures++;
        $display("FAIL hold s=%0d cyc=%0d ov=%b ir=%b p=%h want ov=1 ir=0 p=%h",
                 s, h, get_ov(s), get_ir(s), get_p(s), pv);
      end
    end
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (get_ov(s) !== 1'b0 || get_ir(s) !== 1'b1) begin
      failures++;
      $display("FAIL release s=%0d ov=%b ir=%b want ov=0 ir=1", s, get_ov(s), get_ir(s));
    end
    set_ordy(s, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (get_ir(s) !== 1'b1 || get_ov(s) !== 1'b0 || get_p(s) !== 24'h0) begin
        failures++;
        $display("FAIL reset_state s=%0d ir=%b ov=%b p=%h want ir=1 ov=0 p=0",
                 s, get_ir(s), get_ov(s), get_p(s));
      end
      $display("reset s=%0d ir=%b ov=%b p=%h", s, get_ir(s), get_ov(s), get_p(s));
    end
  endtask

  task automatic test_unsigned_basic();
    do_op(0, 16'd200, 3);
  endtask

  task automatic test_final_carry();
    do_op(0, 16'd255, 0);
    do_op(2, 16'hFFFF, 0);
  endtask

  task automatic test_signed();
    do_op(1, 16'h0088, 2);
    do_op(1, 16'h007F, 0);
    do_op(1, 16'h0080, 0);
    do_op(1, 16'h00FF, 0);
  endtask

  task automatic test_zero();
    do_op(0, 16'h0000, 0);
    do_op(1, 16'h0000, 0);
    do_op(3, 16'h00FF, 0);
    do_op(3, 16'h00A5, 1);
  endtask

  task automatic test_backpressure();
    int lat;
    int e;
    logic [23:0] pv;
    logic [15:0] x1;
    logic [15:0] x2;
    x1 = 16'd77;
    x2 = 16'd201;
    @(negedge clk);
    set_ordy(0, 1'b0);
    set_in(0, 1'b1, x1);
    exp_q.push_back(model(0, x1));
    @(posedge clk); #1;
    set_in(0, 1'b1, x2);
    lat = 0;
    while (get_ov(0) !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL bp_latency1 got=%0d want=2", lat);
    end
    e  = exp_q.pop_front();
    pv = get_p(0);
    checks++;
    if (int'(pv) != e) begin
      failures++;
      $display("FAIL bp_product1 got=%h want=%h", pv, e);
    end
    $display("op s=0 x=%h p=%h exp=%h lat=%0d (backpressure)", x1, pv, e, lat);
    for (int h = 0; h < 5; h++) begin
      @(posedge clk); #1;
      checks++;
      if (get_ov(0) !== 1'b1 || get_ir(0) !== 1'b0 || get_p(0) !== pv) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d ov=%b ir=%b p=%h want ov=1 ir=0 p=%h",
                 h, get_ov(0), get_ir(0), get_p(0), pv);
      end
    end
    set_ordy(0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (get_ov(0) !== 1'b0 || get_ir(0) !== 1'b1) begin
      failures++;
      $display("FAIL bp_idle_visit ov=%b ir=%b want ov=0 ir=1", get_ov(0), get_ir(0));
    end
    exp_q.push_back(model(0, x2));
    @(posedge clk); #1;
    checks++;
    if (get_ir(0) !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept2 ir=%b want=0", get_ir(0));
    end
    set_in(0, 1'b0, 16'h0);
    lat = 0;
    while (get_ov(0) !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL bp_latency2 got=%0d want=2", lat);
    end
    e  = exp_q.pop_front();
    pv = get_p(0);
    checks++;
    if (int'(pv) != e) begin
      failures++;
      $display("FAIL bp_product2 got=%h want=%h", pv, e);
    end
    $display("op s=0 x=%h p=%h exp=%h lat=%0d (queued)", x2, pv, e, lat);
    @(posedge clk); #1;
    set_ordy(0, 1'b0);
  endtask

  task automatic test_reset_in_calc();
    logic seen_ov;
    @(negedge clk);
    set_in(0, 1'b1, 16'd200);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (get_ov(0) !== 1'b0 || get_ir(0) !== 1'b1 || get_p(0) !== 24'h0) begin
      failures++;
      $display("FAIL calc_reset ov=%b ir=%b p=%h want ov=0 ir=1 p=0",
               get_ov(0), get_ir(0), get_p(0));
    end
    rst = 1'b0;
    seen_ov = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (get_ov(0) !== 1'b0) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov !== 1'b0) begin
      failures++;
      $display("FAIL calc_reset_no_output got=%b want=0", seen_ov);
    end
    $display("reset-in-calc s=0 p=%h", get_p(0));
    do_op(0, 16'd99, 0);
  endtask

  task automatic test_back_to_back();
    do_op(1, 16'h0012, 0);
    do_op(1, 16'h00C3, 0);
    do_op(0, 16'h0008, 0);
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) do_op(0, 16'(v), 0);
    for (int v = 0; v < 256; v++) do_op(1, 16'(v), 0);
    do_op(2, 16'h0000, 0);
    do_op(2, 16'h8000, 0);
    do_op(2, 16'h8888, 0);
    for (int k = 0; k < 40; k++) do_op(2, 16'($urandom_range(0, 65535)), 0);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      set_in(s, 1'b0, 16'h0);
      set_ordy(s, 1'b0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_unsigned_basic();
    test_final_carry();
    test_signed();
    test_zero();
    test_backpressure();
    test_reset_in_calc();
    test_back_to_back();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
